// File: rtl/mor1kx_spr_arbiter_cappuccino_if.sv
// ---------------------------------------------------------------------------
// mor1kx_spr_arbiter_cappuccino_if
// Bundles the three buses that meet at the SPR arbiter:
//   cpu_* : ctrl stage l.mfspr/l.mtspr requester (req level, ack pulse, data)
//   du_*  : debug unit requester (stb level, ack pulse, data)
//   spr_* : the shared SPR bus (stb/we/addr/dat out, ack/dat in, timeout pulse)
// Modports:
//   master : the arbiter itself (it drives the SPR bus, answers both requesters)
//   slave  : the surroundings (requesters plus the SPR targets)
// ---------------------------------------------------------------------------
interface mor1kx_spr_arbiter_cappuccino_if #(
    parameter int W  = 32,
    parameter int AW = 16
);
    logic          cpu_req_i;
    logic          cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [W-1:0]  cpu_dat_i;
    logic          cpu_abort_i;
    logic          cpu_ack_o;
    logic [W-1:0]  cpu_dat_o;

    logic          du_stb_i;
    logic          du_we_i;
    logic [AW-1:0] du_addr_i;
    logic [W-1:0]  du_dat_i;
    logic          du_ack_o;
    logic [W-1:0]  du_dat_o;

    logic          spr_stb_o;
    logic          spr_we_o;
    logic [AW-1:0] spr_addr_o;
    logic [W-1:0]  spr_dat_o;
    logic          spr_ack_i;
    logic [W-1:0]  spr_dat_i;
    logic          spr_timeout_o;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_dat_i, cpu_abort_i,
        output cpu_ack_o, cpu_dat_o,
        input  du_stb_i, du_we_i, du_addr_i, du_dat_i,
        output du_ack_o, du_dat_o,
        output spr_stb_o, spr_we_o, spr_addr_o, spr_dat_o, spr_timeout_o,
        input  spr_ack_i, spr_dat_i
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_dat_i, cpu_abort_i,
        input  cpu_ack_o, cpu_dat_o,
        output du_stb_i, du_we_i, du_addr_i, du_dat_i,
        input  du_ack_o, du_dat_o,
        input  spr_stb_o, spr_we_o, spr_addr_o, spr_dat_o, spr_timeout_o,
        output spr_ack_i, spr_dat_i
    );
endinterface

// File: rtl/mor1kx_spr_arbiter_cappuccino.sv
// ---------------------------------------------------------------------------
// mor1kx_spr_arbiter_cappuccino
// Shares the single SPR bus between the ctrl stage and the debug unit. Each
// access runs IDLE -> ACCESS -> RESP: grant one requester, hold the strobe
// until spr_ack_i or SPR_TIMEOUT strobe cycles, then return a one-cycle ack
// with the read data (zero for writes and for timed-out accesses).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of mor1kx_spr_arbiter_cappuccino_if
//              (cpu_* requester, du_* requester, spr_* shared bus)
// ---------------------------------------------------------------------------
module mor1kx_spr_arbiter_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_SPR_ADDR_WIDTH = 16,
    parameter int SPR_TIMEOUT           = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    mor1kx_spr_arbiter_cappuccino_if.master       bus
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int AW = OPTION_SPR_ADDR_WIDTH;
    // One extra bit so the terminal count is representable without wrapping.
    localparam int CW = $clog2(SPR_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPR_TIMEOUT - 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DU  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state,      w_state;
    logic          r_owner,      w_owner;
    logic          r_last_grant, w_last_grant;
    logic          r_we,         w_we;
    logic [AW-1:0] r_addr,       w_addr;
    logic [W-1:0]  r_dat,        w_dat;
    logic [CW-1:0] r_cnt,        w_cnt;
    logic          r_aborted,    w_aborted;
    logic          r_cpu_mask,   w_cpu_mask;
    logic          r_du_mask,    w_du_mask;
    logic          r_stb,        w_stb;
    logic          r_timeout,    w_timeout;
    logic          r_cpu_ack,    w_cpu_ack;
    logic          r_du_ack,     w_du_ack;
    logic [W-1:0]  r_cpu_dat,    w_cpu_dat;
    logic [W-1:0]  r_du_dat,     w_du_dat;

    logic          w_cpu_elig;
    logic          w_du_elig;
    logic          w_grant_du;
    logic          w_done;
    logic [W-1:0]  w_rsp_dat;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_last_grant = r_last_grant;
        w_we         = r_we;
        w_addr       = r_addr;
        w_dat        = r_dat;
        w_cnt        = r_cnt;
        w_aborted    = r_aborted;
        w_cpu_mask   = 1'b0;
        w_du_mask    = 1'b0;
        w_stb        = r_stb;
        w_timeout    = 1'b0;
        w_cpu_ack    = 1'b0;
        w_du_ack     = 1'b0;
        w_cpu_dat    = r_cpu_dat;
        w_du_dat     = r_du_dat;
        w_grant_du   = 1'b0;
        w_done       = 1'b0;
        w_rsp_dat    = {W{1'b0}};

        // A requester just acknowledged sits out one IDLE cycle so its
        // still-asserted level request is not taken as a new access.
        w_cpu_elig = bus.cpu_req_i & ~bus.cpu_abort_i & ~r_cpu_mask;
        w_du_elig  = bus.du_stb_i & ~r_du_mask;

        case (r_state)
            ST_IDLE: begin
                if (w_cpu_elig || w_du_elig) begin
                    // On a tie the requester that did not win last time goes.
                    w_grant_du   = w_du_elig & (~w_cpu_elig | (r_last_grant == OWN_CPU));
                    w_owner      = w_grant_du;
                    w_last_grant = w_grant_du;
                    w_we         = w_grant_du ? bus.du_we_i   : bus.cpu_we_i;
                    w_addr       = w_grant_du ? bus.du_addr_i : bus.cpu_addr_i;
                    w_dat        = w_grant_du ? bus.du_dat_i  : bus.cpu_dat_i;
                    w_cnt        = {CW{1'b0}};
                    w_aborted    = 1'b0;
                    w_stb        = 1'b1;
                    w_state      = ST_ACCESS;
                end else begin
                    w_stb   = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A flush only kills the response; the bus cycle runs to the end.
                if ((r_owner == OWN_CPU) && bus.cpu_abort_i) begin
                    w_aborted = 1'b1;
                end else begin
                    w_aborted = r_aborted;
                end
                // An ack in the terminal cycle beats the timeout.
                if (bus.spr_ack_i) begin
                    w_done    = 1'b1;
                    w_rsp_dat = r_we ? {W{1'b0}} : bus.spr_dat_i;
                end else if (r_cnt == CNT_LAST) begin
                    w_done    = 1'b1;
                    w_rsp_dat = {W{1'b0}};
                    w_timeout = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
                if (w_done) begin
                    w_stb   = 1'b0;
                    w_state = ST_RESP;
                    if (r_owner == OWN_DU) begin
                        w_du_ack = 1'b1;
                        w_du_dat = w_rsp_dat;
                    end else begin
                        w_cpu_ack = ~w_aborted;
                        w_cpu_dat = w_rsp_dat;
                    end
                end else begin
                    w_state = ST_ACCESS;
                end
            end
            ST_RESP: begin
                w_cpu_mask = (r_owner == OWN_CPU);
                w_du_mask  = (r_owner == OWN_DU);
                w_aborted  = 1'b0;
                w_stb      = 1'b0;
                w_state    = ST_IDLE;
            end
            default: begin
                w_stb   = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves the DU as last winner so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DU;
            r_we         <= 1'b0;
            r_addr       <= {AW{1'b0}};
            r_dat        <= {W{1'b0}};
            r_cnt        <= {CW{1'b0}};
            r_aborted    <= 1'b0;
            r_cpu_mask   <= 1'b0;
            r_du_mask    <= 1'b0;
            r_stb        <= 1'b0;
            r_timeout    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_du_ack     <= 1'b0;
            r_cpu_dat    <= {W{1'b0}};
            r_du_dat     <= {W{1'b0}};
        end else begin
            r_state      <= w_state;
            r_owner      <= w_owner;
            r_last_grant <= w_last_grant;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_dat        <= w_dat;
            r_cnt        <= w_cnt;
            r_aborted    <= w_aborted;
            r_cpu_mask   <= w_cpu_mask;
            r_du_mask    <= w_du_mask;
            r_stb        <= w_stb;
            r_timeout    <= w_timeout;
            r_cpu_ack    <= w_cpu_ack;
            r_du_ack     <= w_du_ack;
            r_cpu_dat    <= w_cpu_dat;
            r_du_dat     <= w_du_dat;
        end
    end

    assign bus.spr_stb_o     = r_stb;
    assign bus.spr_we_o      = r_we;
    assign bus.spr_addr_o    = r_addr;
    assign bus.spr_dat_o     = r_dat;
    assign bus.spr_timeout_o = r_timeout;
    assign bus.cpu_ack_o     = r_cpu_ack;
    assign bus.cpu_dat_o     = r_cpu_dat;
    assign bus.du_ack_o      = r_du_ack;
    assign bus.du_dat_o      = r_du_dat;
endmodule
